// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: frame constants and receiver state encoding shared by the
// uart_rx block and its FIFO.
package uart_rx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    UART_RX_IDLE,
    UART_RX_START,
    UART_RX_DATA,
    UART_RX_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead circular receive buffer.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write din when not full (or when a pop happens the same cycle)
//   pop      : drop the head entry; ignored while empty
//   dout     : head entry, reads 0 while empty
//   empty    : no entries held
//   full     : DEPTH entries held
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // When full, a concurrent pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can land there.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with a small receive FIFO.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   RX        : serial line, idle high, asynchronous to clk
//   rd_en     : pop FIFO head (ignored while rx_valid = 0)
//   err_clr   : clear frame_err and overrun
//   rx_data   : FIFO head (show-ahead)
//   rx_valid  : FIFO not empty
//   busy      : a frame is being received
//   frame_err : sticky, stop bit sampled low
//   overrun   : sticky, byte dropped on a full FIFO
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  uart_rx_state_t             state;
  logic [CW-1:0]              cnt;
  logic [2:0]                 bit_idx;
  logic [UART_DATA_BITS-1:0]  shift_reg;
  logic                       rx_meta;
  logic                       rx_s;
  logic                       rx_d;
  logic                       stop_tick;
  logic                       push;
  logic                       frame_set;
  logic                       overrun_set;
  logic                       fifo_empty;
  logic                       fifo_full;

  // Stop-bit decision is made combinationally so the byte is written on the
  // same edge that returns the FSM to IDLE.
  assign stop_tick   = (state == UART_RX_STOP) && (cnt == LAST_CNT);
  assign push        = stop_tick & rx_s;
  assign frame_set   = stop_tick & ~rx_s;
  assign overrun_set = push & fifo_full & ~rd_en;

  assign busy     = (state != UART_RX_IDLE);
  assign rx_valid = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UART_RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;

      case (state)
        UART_RX_IDLE: begin
          if (rx_d && !rx_s) begin
            state <= UART_RX_START;
            cnt   <= '0;
          end
        end
        UART_RX_START: begin
          if (cnt == HALF_CNT) begin
            if (rx_s) begin
              state <= UART_RX_IDLE;
            end else begin
              state   <= UART_RX_DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UART_RX_DATA: begin
          if (cnt == LAST_CNT) begin
            shift_reg[bit_idx] <= rx_s;
            cnt                <= '0;
            if (bit_idx == 3'd7) state <= UART_RX_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UART_RX_STOP: begin
          if (cnt == LAST_CNT) state <= UART_RX_IDLE;
          else                 cnt   <= cnt + 1'b1;
        end
        default: state <= UART_RX_IDLE;
      endcase

      // A set event in the same cycle as err_clr wins.
      frame_err <= frame_set   | (frame_err & ~err_clr);
      overrun   <= overrun_set | (overrun   & ~err_clr);
    end
  end

  uart_rx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shift_reg),
    .pop   (rd_en),
    .dout  (rx_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule
